// File: rtl/register_bank_pkg.sv
// Shared types and constants for the architectural register bank.
// Optional scoreboard is enabled with REGISTER_BANK_SCOREBOARD_EN.
package register_bank_pkg;

    localparam int NR   = 32;
    localparam int XLEN = 32;

    typedef logic [4:0]      regind_t;
    typedef logic [XLEN-1:0] regval_t;

    // Top two indices are architectural specials; register 0 reads as zero
    localparam regind_t Flags = regind_t'(NR - 1);
    localparam regind_t PC    = regind_t'(NR - 2);

    localparam regval_t Nop = '0;

    typedef regval_t regfile_t [NR];
    localparam regfile_t ZeroRegFile = '{default: '0};

    typedef enum logic [1:0] {
        ShiftLl,
        ShiftRl,
        ShiftRa,
        ShiftRr
    } shift_op_t;

endpackage

// File: rtl/register_bank_if.sv
// Read/writeback/claim bus between the pipeline stages and register_bank.
// The hazard output is meaningful only with REGISTER_BANK_SCOREBOARD_EN.
interface register_bank_if #(
    parameter int NREAD = 3,
    parameter int XLEN  = register_bank_pkg::XLEN
);
    import register_bank_pkg::*;

    logic                  hold;
    logic [NREAD-1:0]      rd_request;
    logic [NREAD*5-1:0]    rd_index;
    logic [XLEN-1:0]       rd_pc;
    logic [NREAD*XLEN-1:0] rd_value;

    logic                  wr_enable;
    regind_t               wr_index;
    logic [XLEN-1:0]       wr_value;
    logic                  up_enable;
    logic [XLEN-1:0]       up_value;
    logic                  flags_enable;
    logic [3:0]            flags_value;

    logic                  pc_write;
    logic [XLEN-1:0]       pc_target;

    logic                  claim_enable;
    regind_t               claim_index;
    logic                  hazard;

    modport master (
        output hold, rd_request, rd_index, rd_pc,
        output wr_enable, wr_index, wr_value, up_enable, up_value,
        output flags_enable, flags_value, claim_enable, claim_index,
        input  rd_value, pc_write, pc_target, hazard
    );

    modport slave (
        input  hold, rd_request, rd_index, rd_pc,
        input  wr_enable, wr_index, wr_value, up_enable, up_value,
        input  flags_enable, flags_value, claim_enable, claim_index,
        output rd_value, pc_write, pc_target, hazard
    );

endinterface

// File: rtl/register_scoreboard.sv
// Pending-destination tracking and source hazard detection for register_bank.
// Instantiated only when REGISTER_BANK_SCOREBOARD_EN is defined.
module register_scoreboard #(
    parameter int NR    = 32,
    parameter int NREAD = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     i_claimEnable,
    input  logic [$clog2(NR)-1:0]    i_claimIndex,
    input  logic                     i_wrValid,
    input  logic [$clog2(NR)-1:0]    i_wrIdx,
    input  logic                     i_upValid,
    input  logic [$clog2(NR)-1:0]    i_upIdx,
    input  logic [NREAD-1:0]         i_rdRequest,
    input  logic [NREAD*5-1:0]       i_rdIndex,
    output logic                     o_hazard
);
    import register_bank_pkg::*;

    localparam int IDXW = $clog2(NR);
    localparam int RIW  = $bits(regind_t);
    localparam logic [IDXW-1:0] PC_IDX = IDXW'(NR - 2);

    logic [NR-1:0]   r_pending;
    logic [IDXW-1:0] w_rdIdx [NREAD];
    logic            w_unusedBits;

    for (genvar p = 0; p < NREAD; p++) begin : g_rdIdx
        assign w_rdIdx[p] = i_rdIndex[p*RIW +: IDXW];
    end

    assign w_unusedBits = ^i_rdIndex;

    // Claim is applied after the clears so a same-cycle claim keeps the bit set
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            if (i_wrValid) r_pending[i_wrIdx] <= 1'b0;
            if (i_upValid) r_pending[i_upIdx] <= 1'b0;
            if (i_claimEnable) r_pending[i_claimIndex] <= 1'b1;
            r_pending[0] <= 1'b0;
        end
    end

    always_comb begin
        o_hazard = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            if (i_rdRequest[p] && (w_rdIdx[p] != '0) && (w_rdIdx[p] != PC_IDX) &&
                r_pending[w_rdIdx[p]] &&
                !(i_wrValid && (i_wrIdx == w_rdIdx[p])) &&
                !(i_upValid && (i_upIdx == w_rdIdx[p]))) begin
                o_hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_bank.sv
// Parametrised architectural register file with bypass, upper-value write and PC redirect.
// Define REGISTER_BANK_SCOREBOARD_EN to add the pending-register hazard scoreboard.
module register_bank #(
    parameter int NR    = register_bank_pkg::NR,
    parameter int NREAD = 3,
    parameter int XLEN  = register_bank_pkg::XLEN
) (
    input logic            clock,
    input logic            reset_n,
    register_bank_if.slave bus
);
    import register_bank_pkg::*;

    localparam int IDXW = $clog2(NR);
    localparam int RIW  = $bits(regind_t);
    typedef logic [IDXW-1:0] idx_t;
    localparam idx_t FLAGS_IDX = idx_t'(NR - 1);
    localparam idx_t PC_IDX    = idx_t'(NR - 2);

    logic [XLEN-1:0]       r_regs [NR];
    logic [NREAD*XLEN-1:0] r_rdValue;
    logic                  r_pcWrite;
    logic [XLEN-1:0]       r_pcTarget;

    idx_t                  w_wrIdx;
    idx_t                  w_upIdx;
    logic                  w_wrValid;
    logic                  w_upValid;
    logic                  w_wrPc;
    logic                  w_upPc;
    logic [XLEN-1:0]       w_flagsNext;
    logic [NREAD*XLEN-1:0] w_rdNext;
    idx_t                  w_rdIdx [NREAD];
    logic                  w_unusedBits;

    // Out-of-range indices alias onto the low bits; the upper slot wraps naturally
    assign w_wrIdx   = bus.wr_index[IDXW-1:0];
    assign w_upIdx   = w_wrIdx + idx_t'(1);
    assign w_wrValid = bus.wr_enable && (w_wrIdx != '0);
    assign w_upValid = bus.up_enable && bus.wr_enable && (w_upIdx != '0);
    assign w_wrPc    = w_wrValid && (w_wrIdx == PC_IDX);
    assign w_upPc    = w_upValid && (w_upIdx == PC_IDX);

    for (genvar p = 0; p < NREAD; p++) begin : g_rdIdx
        assign w_rdIdx[p] = bus.rd_index[p*RIW +: IDXW];
    end

    assign w_unusedBits = ^{bus.wr_index, bus.claim_index, bus.rd_index, bus.claim_enable};

    // A full-width write to Flags overrides the 4-bit flags port
    always_comb begin
        w_flagsNext = r_regs[FLAGS_IDX];
        if (w_wrValid && (w_wrIdx == FLAGS_IDX)) begin
            w_flagsNext = bus.wr_value;
        end else if (w_upValid && (w_upIdx == FLAGS_IDX)) begin
            w_flagsNext = bus.up_value;
        end else if (bus.flags_enable) begin
            w_flagsNext = {r_regs[FLAGS_IDX][XLEN-1:4], bus.flags_value};
        end
    end

    always_comb begin
        w_rdNext = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (!bus.rd_request[p] || (w_rdIdx[p] == '0)) begin
                w_rdNext[p*XLEN +: XLEN] = '0;
            end else if (w_rdIdx[p] == PC_IDX) begin
                w_rdNext[p*XLEN +: XLEN] = bus.rd_pc;
            end else if (w_rdIdx[p] == FLAGS_IDX) begin
                w_rdNext[p*XLEN +: XLEN] = w_flagsNext;
            end else if (w_wrValid && (w_wrIdx == w_rdIdx[p])) begin
                w_rdNext[p*XLEN +: XLEN] = bus.wr_value;
            end else if (w_upValid && (w_upIdx == w_rdIdx[p])) begin
                w_rdNext[p*XLEN +: XLEN] = bus.up_value;
            end else begin
                w_rdNext[p*XLEN +: XLEN] = r_regs[w_rdIdx[p]];
            end
        end
    end

    // PC is never stored; a write to it becomes a one-cycle redirect pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) r_regs[i] <= '0;
            r_rdValue  <= '0;
            r_pcWrite  <= 1'b0;
            r_pcTarget <= '0;
        end else begin
            if (!bus.hold) r_rdValue <= w_rdNext;
            r_pcWrite  <= w_wrPc || w_upPc;
            r_pcTarget <= w_wrPc ? bus.wr_value : (w_upPc ? bus.up_value : '0);
            if (w_upValid && (w_upIdx != PC_IDX) && (w_upIdx != FLAGS_IDX)) begin
                r_regs[w_upIdx] <= bus.up_value;
            end
            if (w_wrValid && (w_wrIdx != PC_IDX) && (w_wrIdx != FLAGS_IDX)) begin
                r_regs[w_wrIdx] <= bus.wr_value;
            end
            r_regs[FLAGS_IDX] <= w_flagsNext;
        end
    end

    assign bus.rd_value  = r_rdValue;
    assign bus.pc_write  = r_pcWrite;
    assign bus.pc_target = r_pcTarget;

`ifdef REGISTER_BANK_SCOREBOARD_EN
    register_scoreboard #(
        .NR    (NR),
        .NREAD (NREAD)
    ) u_scoreboard (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_claimEnable (bus.claim_enable),
        .i_claimIndex  (bus.claim_index[IDXW-1:0]),
        .i_wrValid     (w_wrValid),
        .i_wrIdx       (w_wrIdx),
        .i_upValid     (w_upValid),
        .i_upIdx       (w_upIdx),
        .i_rdRequest   (bus.rd_request),
        .i_rdIndex     (bus.rd_index),
        .o_hazard      (bus.hazard)
    );
`else
    assign bus.hazard = 1'b0;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Randomised scoreboard bench for register_bank against a behavioural register-file model.
// Hazard expectations follow REGISTER_BANK_SCOREBOARD_EN when it is defined for the build.
module tb_register_bank;

    localparam int NR    = 32;
    localparam int NREAD = 3;
    localparam int XLEN  = 32;
    localparam int PCI   = NR - 2;
    localparam int FLI   = NR - 1;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    register_bank_if #(.NREAD(NREAD), .XLEN(XLEN)) bus ();

    register_bank #(.NR(NR), .NREAD(NREAD), .XLEN(XLEN)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic                  resetN;
        logic                  hold;
        logic [NREAD-1:0]      req;
        logic [NREAD*5-1:0]    idx;
        logic [XLEN-1:0]       pc;
        logic                  wrEn;
        logic [4:0]            wrIdx;
        logic [XLEN-1:0]       wrVal;
        logic                  upEn;
        logic [XLEN-1:0]       upVal;
        logic                  flEn;
        logic [3:0]            flVal;
        logic                  clEn;
        logic [4:0]            clIdx;
    } stim_t;

    typedef struct {
        int                    cycle;
        logic [NREAD*XLEN-1:0] rd;
        logic                  pcW;
        logic [XLEN-1:0]       pcT;
    } exp_t;

    typedef struct {
        int   cycle;
        logic haz;
    } haz_t;

    exp_t outQ[$];
    haz_t hazQ[$];

    // Reference model state: general registers, flags, pending set, last delivered reads
    logic [XLEN-1:0]       mMem [NR];
    logic [XLEN-1:0]       mFlags;
    bit                    mPend [NR];
    logic [NREAD*XLEN-1:0] mRd;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    function automatic stim_t idle();
        stim_t s;
        s.resetN = 1'b1; s.hold = 1'b0; s.req = '0; s.idx = '0; s.pc = '0;
        s.wrEn = 1'b0; s.wrIdx = '0; s.wrVal = '0; s.upEn = 1'b0; s.upVal = '0;
        s.flEn = 1'b0; s.flVal = '0; s.clEn = 1'b0; s.clIdx = '0;
        return s;
    endfunction

    task automatic checkOutput(input string name, input int cyc,
                               input logic [NREAD*XLEN-1:0] act,
                               input logic [NREAD*XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        int wi, ui, idx, ci;
        bit wv, uv, haz;
        logic [XLEN-1:0] nf, v;
        logic [NREAD*XLEN-1:0] reads;
        exp_t e;
        haz_t h;

        @(negedge clock);
        reset_n          = s.resetN;
        bus.hold         = s.hold;
        bus.rd_request   = s.req;
        bus.rd_index     = s.idx;
        bus.rd_pc        = s.pc;
        bus.wr_enable    = s.wrEn;
        bus.wr_index     = s.wrIdx;
        bus.wr_value     = s.wrVal;
        bus.up_enable    = s.upEn;
        bus.up_value     = s.upVal;
        bus.flags_enable = s.flEn;
        bus.flags_value  = s.flVal;
        bus.claim_enable = s.clEn;
        bus.claim_index  = s.clIdx;
        cycle++;

        e.cycle = cycle;
        if (!s.resetN) begin
            for (int i = 0; i < NR; i++) begin
                mMem[i] = '0;
                mPend[i] = 1'b0;
            end
            mFlags = '0;
            mRd = '0;
            e.rd = '0; e.pcW = 1'b0; e.pcT = '0;
            outQ.push_back(e);
            return;
        end

        wi = int'(s.wrIdx) % NR;
        ui = (wi + 1) % NR;
        wv = s.wrEn && (wi != 0);
        uv = s.upEn && s.wrEn && (ui != 0);

        nf = mFlags;
        if (wv && wi == FLI) nf = s.wrVal;
        else if (uv && ui == FLI) nf = s.upVal;
        else if (s.flEn) nf = {mFlags[XLEN-1:4], s.flVal};

        haz = 1'b0;
        reads = '0;
        for (int p = 0; p < NREAD; p++) begin
            idx = int'(s.idx[p*5 +: 5]) % NR;
            if (!s.req[p] || idx == 0) v = '0;
            else if (idx == PCI) v = s.pc;
            else if (idx == FLI) v = nf;
            else if (wv && wi == idx) v = s.wrVal;
            else if (uv && ui == idx) v = s.upVal;
            else v = mMem[idx];
            reads[p*XLEN +: XLEN] = v;
            if (s.req[p] && idx != 0 && idx != PCI && mPend[idx] &&
                !(wv && wi == idx) && !(uv && ui == idx)) haz = 1'b1;
        end
`ifndef REGISTER_BANK_SCOREBOARD_EN
        haz = 1'b0;
`endif
        h.cycle = cycle;
        h.haz = haz;
        hazQ.push_back(h);

        if (!s.hold) mRd = reads;
        e.rd  = mRd;
        e.pcW = (wv && wi == PCI) || (uv && ui == PCI);
        e.pcT = (wv && wi == PCI) ? s.wrVal : ((uv && ui == PCI) ? s.upVal : '0);
        outQ.push_back(e);

        if (uv && ui != PCI && ui != FLI) mMem[ui] = s.upVal;
        if (wv && wi != PCI && wi != FLI) mMem[wi] = s.wrVal;
        mFlags = nf;
        if (wv) mPend[wi] = 1'b0;
        if (uv) mPend[ui] = 1'b0;
        ci = int'(s.clIdx) % NR;
        if (s.clEn && ci != 0) mPend[ci] = 1'b1;
    endtask

    function automatic logic [4:0] randIdx();
        case ($urandom_range(0, 5))
            0: return 5'd0;
            1: return 5'(PCI);
            2: return 5'(FLI);
            3: return 5'($urandom_range(1, 4));
            default: return 5'($urandom_range(0, NR - 1));
        endcase
    endfunction

    // Monitor: hazard mid-low-phase, registered outputs just after each rising edge
    initial begin
        haz_t h;
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (hazQ.size() > 0) begin
                h = hazQ.pop_front();
                checkOutput("hazard", h.cycle, {95'b0, bus.hazard}, {95'b0, h.haz});
            end
            @(posedge clock);
            #1;
            if (outQ.size() > 0) begin
                e = outQ.pop_front();
                checkOutput("rd_value", e.cycle, bus.rd_value, e.rd);
                checkOutput("pc_write", e.cycle, {95'b0, bus.pc_write}, {95'b0, e.pcW});
                checkOutput("pc_target", e.cycle, {64'b0, bus.pc_target}, {64'b0, e.pcT});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        reset_n = 1'b0;
        bus.hold = 1'b0; bus.rd_request = '0; bus.rd_index = '0; bus.rd_pc = '0;
        bus.wr_enable = 1'b0; bus.wr_index = '0; bus.wr_value = '0;
        bus.up_enable = 1'b0; bus.up_value = '0; bus.flags_enable = 1'b0;
        bus.flags_value = '0; bus.claim_enable = 1'b0; bus.claim_index = '0;

        s = idle(); s.resetN = 1'b0;
        repeat (2) applyStimulus(s);

        s = idle(); s.wrEn = 1; s.wrIdx = 5; s.wrVal = 32'h1234; applyStimulus(s);
        s = idle(); s.req = 3'b001; s.idx[0 +: 5] = 5; applyStimulus(s);
        s = idle(); s.wrEn = 1; s.wrIdx = 0; s.wrVal = 32'hFFFF; applyStimulus(s);
        s = idle(); s.req = 3'b001; s.idx[0 +: 5] = 0; applyStimulus(s);

        s = idle(); s.wrEn = 1; s.wrIdx = 7; s.wrVal = 32'hAA; s.req = 3'b010; s.idx[5 +: 5] = 7;
        applyStimulus(s);
        s = idle(); s.hold = 1; s.req = 3'b010; s.idx[5 +: 5] = 5; applyStimulus(s);
        applyStimulus(s);

        s = idle(); s.wrEn = 1; s.wrIdx = 3; s.wrVal = 32'h1; s.upEn = 1; s.upVal = 32'h2;
        applyStimulus(s);
        s = idle(); s.req = 3'b011; s.idx[0 +: 5] = 3; s.idx[5 +: 5] = 4; applyStimulus(s);
        s = idle(); s.wrEn = 1; s.wrIdx = 5'(FLI); s.wrVal = 32'hFFFF_FFF0; s.upEn = 1;
        s.upVal = 32'h77; applyStimulus(s);
        s = idle(); s.req = 3'b011; s.idx[0 +: 5] = 0; s.idx[5 +: 5] = 5'(FLI); applyStimulus(s);

        s = idle(); s.flEn = 1; s.flVal = 4'hB; s.req = 3'b100; s.idx[10 +: 5] = 5'(FLI);
        applyStimulus(s);
        s = idle(); s.flEn = 1; s.flVal = 4'hC; s.wrEn = 1; s.wrIdx = 5'(FLI); s.wrVal = 32'h5;
        s.req = 3'b100; s.idx[10 +: 5] = 5'(FLI); applyStimulus(s);

        s = idle(); s.wrEn = 1; s.wrIdx = 5'(PCI); s.wrVal = 32'h400; applyStimulus(s);
        s = idle(); s.req = 3'b001; s.idx[0 +: 5] = 5'(PCI); s.pc = 32'h88; applyStimulus(s);
        applyStimulus(idle());

        s = idle(); s.clEn = 1; s.clIdx = 9; applyStimulus(s);
        s = idle(); s.req = 3'b001; s.idx[0 +: 5] = 9; applyStimulus(s);
        s = idle(); s.req = 3'b001; s.idx[0 +: 5] = 9; s.wrEn = 1; s.wrIdx = 9; s.wrVal = 32'h99;
        applyStimulus(s);
        s = idle(); s.clEn = 1; s.clIdx = 9; s.wrEn = 1; s.wrIdx = 9; s.wrVal = 32'h9A;
        applyStimulus(s);
        s = idle(); s.req = 3'b001; s.idx[0 +: 5] = 9; applyStimulus(s);
        s = idle(); s.wrEn = 1; s.wrIdx = 9; s.wrVal = 32'h9B; applyStimulus(s);

        for (int n = 0; n < 2000; n++) begin
            s = idle();
            s.resetN = ($urandom_range(0, 299) != 0);
            s.hold   = ($urandom_range(0, 3) == 0);
            s.req    = 3'($urandom);
            for (int p = 0; p < NREAD; p++) s.idx[p*5 +: 5] = randIdx();
            s.pc     = $urandom;
            s.wrEn   = ($urandom_range(0, 1) == 0);
            s.wrIdx  = randIdx();
            s.wrVal  = $urandom;
            s.upEn   = ($urandom_range(0, 2) == 0);
            s.upVal  = $urandom;
            s.flEn   = ($urandom_range(0, 3) == 0);
            s.flVal  = 4'($urandom);
            s.clEn   = ($urandom_range(0, 2) == 0);
            s.clIdx  = randIdx();
            applyStimulus(s);
        end

        repeat (3) @(negedge clock);
        checkOutput("queue_drain", cycle, 96'(outQ.size() + hazQ.size()), 96'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
